// File: rtl/updown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : updown_pkg
// Description : Shared definitions for the up/down guessing-game controller:
//               hint encodings, FSM state encoding, default sizing and a
//               saturating attempt-counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package updown_pkg;

    localparam int c_DEFAULT_MAX_TRIES = 10;
    localparam int c_DEFAULT_NUM_W     = 7;
    localparam int c_ATTEMPTS_W        = 4;

    typedef enum logic [1:0] {
        HINT_NONE    = 2'b00,
        HINT_UP      = 2'b01,   // secret > guess
        HINT_DOWN    = 2'b10,   // secret < guess
        HINT_CORRECT = 2'b11
    } hint_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_WAIT_GUESS = 3'd3,
        ST_EVAL       = 3'd4,
        ST_WIN        = 3'd5,
        ST_LOSE       = 3'd6
    } state_t;

    // Attempt counter stops at all-ones instead of wrapping.
    function automatic logic [c_ATTEMPTS_W-1:0] sat_inc(input logic [c_ATTEMPTS_W-1:0] v);
        return (v == {c_ATTEMPTS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updown_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : updown_edge_det
// Description : Rising-edge detector for the guess strobe. The history
//               register updates every cycle regardless of game state, so a
//               strobe already high when the game starts listening never
//               looks like a new edge.
// Ports       : clk       - clock
//               rst       - asynchronous active-high reset (clears history)
//               i_trigger - raw strobe
//               o_rise    - high in the cycle where i_trigger=1 and was 0
// Revision    : 1.0 - initial release
// ============================================================================
module updown_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_trigger,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_trigger;
        end
    end

    assign o_rise = i_trigger & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/updown_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : updown_game_ctrl
// Description : Controller for a number-guessing game. Requests a secret from
//               a random source, evaluates player guesses and reports
//               UP/DOWN/CORRECT hints, counts attempts and declares win/lose.
// Config      : UPDOWN_RANGE_TRACK_EN - when defined, tracks the legal guess
//               window [range_lo, range_hi] from previous hints and rejects
//               guesses outside it (invalid pulse, no attempt consumed).
// Ports       : clk, reset (async, active-high)
//               start         - level, begins/restarts a round
//               guess_trigger - guess strobe (rising edge used)
//               user_input    - player guess
//               secret_in     - random source value, sampled in CAPTURE
//               secret_req    - one-cycle request to the random source
//               hint/hint_valid/invalid/attempts - per-guess results
//               win/lose      - round result, held until next start
//               busy          - round in progress
//               range_lo/range_hi - current legal guess bounds
// Revision    : 1.0 - initial release
// ============================================================================
module updown_game_ctrl
    import updown_pkg::*;
#(
    parameter int MAX_TRIES = c_DEFAULT_MAX_TRIES,
    parameter int NUM_W     = c_DEFAULT_NUM_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    guess_trigger,
    input  logic [NUM_W-1:0]        user_input,
    input  logic [NUM_W-1:0]        secret_in,
    output logic                    secret_req,
    output logic [1:0]              hint,
    output logic                    hint_valid,
    output logic                    invalid,
    output logic [c_ATTEMPTS_W-1:0] attempts,
    output logic                    win,
    output logic                    lose,
    output logic                    busy,
    output logic [NUM_W-1:0]        range_lo,
    output logic [NUM_W-1:0]        range_hi
);

    localparam logic [c_ATTEMPTS_W-1:0] c_MAX_TRIES = c_ATTEMPTS_W'(MAX_TRIES);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [NUM_W-1:0]          r_secret;
    logic [NUM_W-1:0]          r_guess;
    hint_t                     r_hint;
    logic                      r_hint_valid;
    logic [c_ATTEMPTS_W-1:0]   r_attempts;
    logic                      r_win;
    logic                      r_lose;
    logic                      w_guess_rise;
    logic                      w_restart;
    logic                      w_out_of_range;
    logic [c_ATTEMPTS_W-1:0]   w_attempts_inc;

    updown_edge_det u_edge_det (
        .clk       (clk),
        .rst       (reset),
        .i_trigger (guess_trigger),
        .o_rise    (w_guess_rise)
    );

    // Start has priority over everything, including a same-cycle guess edge.
    // LOAD is excluded so the single-cycle secret request always completes.
    assign w_restart      = start && (r_state != ST_LOAD);
    assign w_attempts_inc = sat_inc(r_attempts);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_restart) begin
            w_next_state = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:       w_next_state = ST_CAPTURE;
                ST_CAPTURE:    w_next_state = ST_WAIT_GUESS;
                ST_WAIT_GUESS: if (w_guess_rise) w_next_state = ST_EVAL;
                ST_EVAL: begin
                    if (w_out_of_range) begin
                        w_next_state = ST_WAIT_GUESS;
                    end else if (r_guess == r_secret) begin
                        w_next_state = ST_WIN;
                    end else if (w_attempts_inc >= c_MAX_TRIES) begin
                        w_next_state = ST_LOSE;
                    end else begin
                        w_next_state = ST_WAIT_GUESS;
                    end
                end
                ST_IDLE, ST_WIN, ST_LOSE: w_next_state = r_state;
                default:       w_next_state = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: secret/guess capture and per-guess results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_secret     <= '0;
            r_guess      <= '0;
            r_hint       <= HINT_NONE;
            r_hint_valid <= 1'b0;
            r_attempts   <= '0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else begin
            r_hint_valid <= 1'b0;
            if (w_restart) begin
                r_hint     <= HINT_NONE;
                r_attempts <= '0;
                r_win      <= 1'b0;
                r_lose     <= 1'b0;
            end else begin
                case (r_state)
                    ST_CAPTURE: r_secret <= secret_in;
                    ST_WAIT_GUESS: begin
                        if (w_guess_rise) r_guess <= user_input;
                    end
                    ST_EVAL: begin
                        r_hint_valid <= 1'b1;
                        if (w_out_of_range) begin
                            // Rejected guess does not consume an attempt.
                            r_hint <= HINT_NONE;
                        end else begin
                            r_attempts <= w_attempts_inc;
                            if (r_guess == r_secret) begin
                                r_hint <= HINT_CORRECT;
                                r_win  <= 1'b1;
                            end else begin
                                r_hint <= (r_secret > r_guess) ? HINT_UP : HINT_DOWN;
                                if (w_attempts_inc >= c_MAX_TRIES) r_lose <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef UPDOWN_RANGE_TRACK_EN
    // ------------------------------------------------------------------
    // Legal-window tracking. UP/DOWN hints only occur when the guess is
    // strictly below/above the secret, so guess+1 / guess-1 cannot wrap.
    // ------------------------------------------------------------------
    logic [NUM_W-1:0] r_range_lo;
    logic [NUM_W-1:0] r_range_hi;
    logic             r_invalid;

    assign w_out_of_range = (r_guess < r_range_lo) || (r_guess > r_range_hi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_range_lo <= '0;
            r_range_hi <= '1;
            r_invalid  <= 1'b0;
        end else begin
            r_invalid <= 1'b0;
            if (w_restart) begin
                r_range_lo <= '0;
                r_range_hi <= '1;
            end else if (r_state == ST_EVAL) begin
                if (w_out_of_range) begin
                    r_invalid <= 1'b1;
                end else if (r_secret > r_guess) begin
                    r_range_lo <= r_guess + 1'b1;
                end else if (r_secret < r_guess) begin
                    r_range_hi <= r_guess - 1'b1;
                end
            end
        end
    end

    assign range_lo = r_range_lo;
    assign range_hi = r_range_hi;
    assign invalid  = r_invalid;
`else
    assign w_out_of_range = 1'b0;
    assign range_lo       = '0;
    assign range_hi       = '1;
    assign invalid        = 1'b0;
`endif

    assign secret_req = (r_state == ST_LOAD);
    assign busy       = !((r_state == ST_IDLE) || (r_state == ST_WIN) || (r_state == ST_LOSE));
    assign hint       = r_hint;
    assign hint_valid = r_hint_valid;
    assign attempts   = r_attempts;
    assign win        = r_win;
    assign lose       = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_updown_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_game_ctrl
// Description : Scoreboard bench for updown_game_ctrl (MAX_TRIES=3, NUM_W=7).
//               Each issued guess queues its expected hint record; a monitor
//               pops one record per hint_valid pulse. Direct checks cover
//               reset values, secret_req pulses and held results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_game_ctrl;
    import updown_pkg::*;

    localparam int NUM_W     = 7;
    localparam int MAX_TRIES = 3;

    localparam logic [1:0] c_NONE = 2'b00;
    localparam logic [1:0] c_UP   = 2'b01;
    localparam logic [1:0] c_DOWN = 2'b10;
    localparam logic [1:0] c_COR  = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             guess_trigger;
    logic [NUM_W-1:0] user_input;
    logic [NUM_W-1:0] secret_in;
    logic             secret_req;
    logic [1:0]       w_hint;
    logic             w_hint_valid;
    logic             invalid;
    logic [3:0]       attempts;
    logic             win;
    logic             lose;
    logic             busy;
    logic [NUM_W-1:0] range_lo;
    logic [NUM_W-1:0] range_hi;

    typedef struct packed {
        logic [1:0] hint;
        logic       invalid;
        logic [3:0] attempts;
        logic       win;
        logic       lose;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    updown_game_ctrl #(
        .MAX_TRIES (MAX_TRIES),
        .NUM_W     (NUM_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .guess_trigger (guess_trigger),
        .user_input    (user_input),
        .secret_in     (secret_in),
        .secret_req    (secret_req),
        .hint          (w_hint),
        .hint_valid    (w_hint_valid),
        .invalid       (invalid),
        .attempts      (attempts),
        .win           (win),
        .lose          (lose),
        .busy          (busy),
        .range_lo      (range_lo),
        .range_hi      (range_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every hint_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (w_hint_valid) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_hint_valid: got pulse hint=%0d attempts=%0d, expected none (t=%0t)",
                             w_hint, attempts, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_hint",     w_hint,   mon_e.hint);
                    check("sb_invalid",  invalid,  mon_e.invalid);
                    check("sb_attempts", attempts, mon_e.attempts);
                    check("sb_win",      win,      mon_e.win);
                    check("sb_lose",     lose,     mon_e.lose);
                end
            end else if (invalid) begin
                check("invalid_without_hint_valid", invalid, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hint"},       w_hint,       0);
        check({tag, "_hint_valid"}, w_hint_valid, 0);
        check({tag, "_invalid"},    invalid,      0);
        check({tag, "_attempts"},   attempts,     0);
        check({tag, "_win"},        win,          0);
        check({tag, "_lose"},       lose,         0);
        check({tag, "_busy"},       busy,         0);
        check({tag, "_secret_req"}, secret_req,   0);
        check({tag, "_range_lo"},   range_lo,     0);
        check({tag, "_range_hi"},   range_hi,     127);
    endtask

    task automatic do_start(input logic [NUM_W-1:0] s);
        secret_in = s;
        start     = 1'b1;
        tick();                         // now in LOAD
        start = 1'b0;
        check("load_secret_req", secret_req, 1);
        check("load_attempts",   attempts,   0);
        check("load_hint",       w_hint,     0);
        check("load_win",        win,        0);
        check("load_lose",       lose,       0);
        check("load_busy",       busy,       1);
        tick();                         // CAPTURE
        check("capture_secret_req", secret_req, 0);
        tick();                         // WAIT_GUESS
    endtask

    task automatic do_guess(input logic [NUM_W-1:0] g, input logic [1:0] h, input logic inv,
                            input logic [3:0] att, input logic w, input logic l);
        sb_q.push_back(exp_t'{h, inv, att, w, l});
        user_input    = g;
        guess_trigger = 1'b1;
        tick();                         // edge N: guess captured, EVAL
        guess_trigger = 1'b0;
        tick();                         // edge N+1: hint_valid
        tick();
    endtask

    task automatic ignored_trigger();
        user_input    = 7'd1;
        guess_trigger = 1'b1;
        tick();
        guess_trigger = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        guess_trigger = 1'b0;
        user_input    = '0;
        secret_in     = '0;
        repeat (2) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();
        check_reset_values("idle");

        // Basic round: UP, DOWN, CORRECT on the final allowed try -> WIN.
        do_start(7'd42);
        do_guess(7'd20, c_UP,   1'b0, 4'd1, 1'b0, 1'b0);
        do_guess(7'd60, c_DOWN, 1'b0, 4'd2, 1'b0, 1'b0);
        do_guess(7'd42, c_COR,  1'b0, 4'd3, 1'b1, 1'b0);
        check("win_held",  win,  1);
        check("win_busy",  busy, 0);
        ignored_trigger();
        check("win_after_trigger",      win,      1);
        check("win_attempts_unchanged", attempts, 3);

        // Exhausted tries -> LOSE, results held.
        do_start(7'd10);
        do_guess(7'd0, c_UP, 1'b0, 4'd1, 1'b0, 1'b0);
        do_guess(7'd1, c_UP, 1'b0, 4'd2, 1'b0, 1'b0);
        do_guess(7'd2, c_UP, 1'b0, 4'd3, 1'b0, 1'b1);
        check("lose_held", lose, 1);
        check("lose_busy", busy, 0);
        ignored_trigger();
        check("lose_after_trigger",      lose,     1);
        check("lose_attempts_unchanged", attempts, 3);

        // Boundary secrets 0 and 2^NUM_W-1.
        do_start(7'd0);
        do_guess(7'd5, c_DOWN, 1'b0, 4'd1, 1'b0, 1'b0);
        do_guess(7'd0, c_COR,  1'b0, 4'd2, 1'b1, 1'b0);
        do_start(7'd127);
        do_guess(7'd127, c_COR, 1'b0, 4'd1, 1'b1, 1'b0);

        // Trigger held high for 20 cycles -> exactly one evaluation.
        do_start(7'd100);
        sb_q.push_back(exp_t'{c_UP, 1'b0, 4'd1, 1'b0, 1'b0});
        user_input    = 7'd5;
        guess_trigger = 1'b1;
        repeat (20) tick();
        guess_trigger = 1'b0;
        tick();
        check("held_attempts", attempts, 1);

        // Start and guess edge in the same cycle: start wins, guess dropped,
        // and the still-high trigger does not fire on WAIT_GUESS entry.
        user_input    = 7'd77;
        secret_in     = 7'd77;
        start         = 1'b1;
        guess_trigger = 1'b1;
        tick();
        start = 1'b0;
        check("same_cycle_secret_req", secret_req, 1);
        check("same_cycle_attempts",   attempts,   0);
        tick();
        check("same_cycle_capture_req", secret_req, 0);
        repeat (5) tick();
        check("same_cycle_busy",       busy,     1);
        check("same_cycle_no_attempt", attempts, 0);
        guess_trigger = 1'b0;
        tick();
        do_guess(7'd77, c_COR, 1'b0, 4'd1, 1'b1, 1'b0);

        // Range tracking behaviour depends on the build configuration.
        do_start(7'd50);
        do_guess(7'd30, c_UP, 1'b0, 4'd1, 1'b0, 1'b0);
`ifdef UPDOWN_RANGE_TRACK_EN
        check("range_lo_after_up", range_lo, 31);
        check("range_hi_after_up", range_hi, 127);
        do_guess(7'd20, c_NONE, 1'b1, 4'd1, 1'b0, 1'b0);
        check("range_lo_after_invalid", range_lo, 31);
        do_guess(7'd50, c_COR, 1'b0, 4'd2, 1'b1, 1'b0);
`else
        check("range_lo_const", range_lo, 0);
        check("range_hi_const", range_hi, 127);
        do_guess(7'd20, c_UP, 1'b0, 4'd2, 1'b0, 1'b0);
        do_guess(7'd50, c_COR, 1'b0, 4'd3, 1'b1, 1'b0);
`endif

        // Reset while in EVAL abandons the round with no hint pulse.
        do_start(7'd42);
        do_guess(7'd20, c_UP, 1'b0, 4'd1, 1'b0, 1'b0);
        user_input    = 7'd5;
        guess_trigger = 1'b1;
        tick();                         // now in EVAL
        reset = 1'b1;
        #1;
        guess_trigger = 1'b0;
        check_reset_values("mid_eval_reset");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check_reset_values("after_reset");

        repeat (5) tick();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_game_ctrl.md
UPDOWN_GAME_CTRL -- requirements
Module: updown_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 10, number of guesses allowed per round (1..15).
REQ-002 SHALL have parameter NUM_W, default 7, width of secret and guess values.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  level; begins or restarts a round.
REQ-006 guess_trigger  in  1  guess strobe; rising edge detected internally.
REQ-007 user_input  in  NUM_W  player guess, unsigned.
REQ-008 secret_in  in  NUM_W  value from random-number source.
REQ-009 secret_req  out  1  one-cycle request to random source.
REQ-010 hint  out  2  00 NONE, 01 UP (secret > guess), 10 DOWN (secret < guess), 11 CORRECT.
REQ-011 hint_valid  out  1  one-cycle pulse when hint/attempts update.
REQ-012 invalid  out  1  one-cycle pulse: guess outside tracked range.
REQ-013 attempts  out  4  guesses consumed this round.
REQ-014 win, lose  out  1 each  round result, held until next start.
REQ-015 busy  out  1  high in all states except IDLE, WIN, LOSE.
REQ-016 range_lo, range_hi  out  NUM_W each  current legal guess bounds.

Function
REQ-017 SHALL implement states IDLE, LOAD, CAPTURE, WAIT_GUESS, EVAL, WIN, LOSE.
REQ-018 start=1 in any non-LOAD state SHALL go to LOAD next edge, clearing attempts, hint, win, lose, bounds to 0/2^NUM_W-1.
REQ-019 LOAD SHALL assert secret_req for exactly one cycle, then CAPTURE.
REQ-020 CAPTURE SHALL register secret_in into secret_q, then WAIT_GUESS; secret 0 and 2^NUM_W-1 legal.
REQ-021 Rising edge = guess_trigger=1 this cycle, 0 previous cycle; detector tracks in every state.
REQ-022 Edge seen in WAIT_GUESS at edge N SHALL register user_input, go to EVAL; hint_valid, hint, attempts update at edge N+1 (latency 2).
REQ-023 Edges outside WAIT_GUESS SHALL be ignored; trigger held high across WAIT_GUESS entry SHALL NOT fire.
REQ-024 EVAL: equal -> CORRECT, WIN, win=1; else UP/DOWN, attempts+1; if attempts reaches MAX_TRIES -> LOSE, lose=1; else WAIT_GUESS.
REQ-025 Correct guess SHALL also increment attempts; correct on final try SHALL give WIN, not LOSE.
REQ-026 Comparison unsigned at NUM_W; attempts saturates at 15.
REQ-027 start and guess edge same cycle: start wins, guess dropped.
REQ-028 WIN/LOSE SHALL hold until start; guesses ignored.

Reset
REQ-029 Reset SHALL force IDLE, secret_q=0, hint=00, hint_valid=0, invalid=0, attempts=0, win=lose=0, secret_req=0, busy=0, range_lo=0, range_hi=2^NUM_W-1, edge history=0.
REQ-030 Reset mid-round SHALL abandon round with no hint_valid pulse.

Configuration
REQ-031 Macro UPDOWN_RANGE_TRACK_EN SHALL gate range tracking.
REQ-032 Defined: UP sets range_lo=guess+1, DOWN sets range_hi=guess-1; guess outside [lo,hi] pulses invalid and hint_valid with hint NONE, attempts unchanged, back to WAIT_GUESS.
REQ-033 Undefined: invalid tied 0, range_lo=0, range_hi=2^NUM_W-1 constant, all guesses evaluated.

Structure
REQ-034 Package updown_pkg SHALL hold hint encodings, state enum, default MAX_TRIES, NUM_W.
REQ-035 Sub-module updown_edge_det SHALL implement rising-edge detection of guess_trigger.

Verification
REQ-036 start, secret_in=42, guesses 20,60,42 -> hints UP, DOWN, CORRECT; attempts 3; win=1.
REQ-037 MAX_TRIES=3, secret 10, guesses 0,1,2 -> third hint UP, lose=1, attempts 3; further triggers ignored.
REQ-038 guess_trigger held high 20 cycles in WAIT_GUESS -> exactly one hint_valid.
REQ-039 start and trigger rise same cycle -> LOAD, secret_req pulse, no hint_valid.
REQ-040 Reset during EVAL -> all outputs at reset values next cycle, no hint_valid.
REQ-041 With UPDOWN_RANGE_TRACK_EN, secret 50: guess 30 (UP, lo=31), guess 20 -> invalid pulse, attempts 1; without macro guess 20 -> UP, attempts 2.
